// File: rtl/wos_pkg.sv
// wos_pkg: opcodes, FSM states and status bit positions shared by the wire_op_sequencer blocks
package wos_pkg;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ILLEGAL = 2;
    localparam int ST_OVERRUN = 3;
    localparam int ST_CNT_LSB = 16;
endpackage

// File: rtl/wos_mul_unit.sv
// wos_mul_unit: iterative shift-add unsigned multiplier, one bit per cycle.
// Ports: okClk clock, rst sync reset, go load strobe, a/b operands,
// product 2*WIDTH result, done one-cycle pulse once product is final.
// The first partial product is formed in the go cycle, so done arrives
// WIDTH cycles after go.
module wos_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 okClk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic             busy;
    // product holds {partial sum, remaining multiplier bits}; shift right each step
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {s, p[WIDTH-1:1]};
    endfunction
    always_ff @(posedge okClk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (go) begin
                mcand   <= a;
                product <= step({{WIDTH{1'b0}}, b}, a);
                cnt     <= CW'(1);
                busy    <= 1'b1;
            end else if (busy) begin
                product <= step(product, mcand);
                cnt     <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/wire_op_sequencer.sv
// wire_op_sequencer: host-commanded logic/arithmetic sequencer on okClk.
// Ports: okClk clock, rst sync reset, start command strobe, opcode/operand_a/operand_b
// command inputs, result_lo/result_hi held results, status {cmd_count, 12'b0,
// overrun, illegal_op, done, busy}, done_pulse completion strobe, led (WOS_LED_EN only).
module wire_op_sequencer
    import wos_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             okClk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [31:0]      status,
    output logic             done_pulse
`ifdef WOS_LED_EN
    ,
    output wire  [3:0]       led
`endif
);
    state_t             state, state_nxt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [3:0]         flags;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] res, mul_prod;
    logic               mul_done, accept, finish;
    assign accept = (state == S_IDLE) && start;
    assign finish = (state == S_EXEC) && ((op_q != OP_MUL) || mul_done);
    assign status = (32'(cnt) << ST_CNT_LSB) | 32'(flags);
    wos_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .okClk   (okClk),
        .rst     (rst),
        .go      (accept && (opcode == OP_MUL)),
        .a       (operand_a),
        .b       (operand_b),
        .product (mul_prod),
        .done    (mul_done)
    );
    always_comb begin
        res = (op_q == OP_AND) ? {{WIDTH{1'b0}}, a_q & b_q} :
              (op_q == OP_OR)  ? {{WIDTH{1'b0}}, a_q | b_q} :
              (op_q == OP_XOR) ? {{WIDTH{1'b0}}, a_q ^ b_q} :
              (op_q == OP_ADD) ? {{(WIDTH-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}} : mul_prod;
    end
    always_comb begin
        state_nxt = accept ? S_EXEC : finish ? S_DONE : (state == S_DONE) ? S_IDLE : state;
    end
    always_ff @(posedge okClk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge okClk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            flags      <= '0;
            cnt        <= '0;
            result_lo  <= '0;
            result_hi  <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= finish;
            if (accept) begin
                op_q               <= opcode;
                a_q                <= operand_a;
                b_q                <= operand_b;
                flags[ST_BUSY]     <= 1'b1;
                flags[ST_DONE]     <= 1'b0;
                flags[ST_ILLEGAL]  <= 1'b0;
                flags[ST_OVERRUN]  <= 1'b0;
            end else if (start) begin
                flags[ST_OVERRUN]  <= 1'b1;
            end
            if (finish) begin
                flags[ST_BUSY]    <= 1'b0;
                flags[ST_DONE]    <= 1'b1;
                flags[ST_ILLEGAL] <= op_q > OP_MUL;
                cnt               <= cnt + CNT_W'(1);
                if (op_q <= OP_MUL) {result_hi, result_lo} <= res;
            end
        end
    end
`ifdef WOS_LED_EN
    for (genvar i = 0; i < 4; i++) begin : g_led
        assign led[i] = status[i] ? 1'b0 : 1'bz;
    end
`endif
endmodule

// File: tb/tb_wire_op_sequencer.sv
// tb_wire_op_sequencer: directed vector bench for wire_op_sequencer
module tb_wire_op_sequencer;
    import wos_pkg::*;
    logic        okClk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0]  opcode = '0;
    logic [31:0] operand_a = '0, operand_b = '0;
    logic [31:0] result_lo, result_hi, status, r2_lo, r2_hi, status2;
    logic        done_pulse, dp2;
    int          n_checks = 0, n_fail = 0, exp_cnt = 0, lat = 0, pulses = 0;
`ifdef WOS_LED_EN
    wire [3:0] led, led2;
`endif
    always #5 okClk = ~okClk;
    wire_op_sequencer dut (
        .okClk(okClk), .rst(rst), .start(start), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .result_lo(result_lo), .result_hi(result_hi), .status(status), .done_pulse(done_pulse)
`ifdef WOS_LED_EN
        , .led(led)
`endif
    );
    wire_op_sequencer #(.CNT_W(2)) dut2 (
        .okClk(okClk), .rst(rst), .start(start), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .result_lo(r2_lo), .result_hi(r2_hi), .status(status2), .done_pulse(dp2)
`ifdef WOS_LED_EN
        , .led(led2)
`endif
    );
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        ill;
        int          lat;
    } vec_t;
    vec_t v[11];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge okClk);
        #1;
    endtask
    function automatic logic [31:0] es(input int c, input logic ill, input logic ov, input logic bz, input logic dn);
        logic [15:0] c16;
        c16 = 16'(c);
        return {c16, 12'b0, ov, ill, dn, bz};
    endfunction
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        opcode = op; operand_a = a; operand_b = b; start = 1'b1;
        tick();
        start = 1'b0; opcode = ~op; operand_a = ~a; operand_b = ~b;
        chk("busy_exec", 64'(status[ST_BUSY]), 64'(1));
        n = 1;
        while (!done_pulse && n < 100) begin
            tick();
            n++;
        end
        if (done_pulse) exp_cnt++;
    endtask
    initial begin
        v[0]  = '{OP_OR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 32'h0,         1'b0, 2};
        v[1]  = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 32'h0,         1'b0, 2};
        v[2]  = '{OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 32'h0,         1'b0, 2};
        v[3]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         32'h1,         1'b0, 2};
        v[4]  = '{OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'h0,         1'b0, 2};
        v[5]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33};
        v[6]  = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,         32'h1,         1'b0, 33};
        v[7]  = '{OP_MUL, 32'h0000_1234, 32'h0000_0001, 32'h0000_1234, 32'h0,         1'b0, 33};
        v[8]  = '{3'd6,   32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_1234, 32'h0,         1'b1, 2};
        v[9]  = '{3'd5,   32'h1,         32'h2,         32'h0000_1234, 32'h0,         1'b1, 2};
        v[10] = '{OP_AND, 32'h0,         32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 2};
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_lo", 64'(result_lo), 64'(0));
        chk("rst_hi", 64'(result_hi), 64'(0));
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_pulse", 64'(done_pulse), 64'(0));
        chk("rst_status2", 64'(status2), 64'(0));
        for (int i = 0; i < 11; i++) begin
            issue(v[i].op, v[i].a, v[i].b, lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(v[i].lat));
            chk($sformatf("v%0d_lo", i), 64'(result_lo), 64'(v[i].lo));
            chk($sformatf("v%0d_hi", i), 64'(result_hi), 64'(v[i].hi));
            chk($sformatf("v%0d_status", i), 64'(status), 64'(es(exp_cnt, v[i].ill, 1'b0, 1'b0, 1'b1)));
            chk($sformatf("v%0d_status2", i), 64'(status2), 64'(es(exp_cnt % 4, v[i].ill, 1'b0, 1'b0, 1'b1)));
            chk($sformatf("v%0d_r2", i), {r2_hi, r2_lo}, {v[i].hi, v[i].lo});
            chk($sformatf("v%0d_dp2", i), 64'(dp2), 64'(1));
`ifdef WOS_LED_EN
            if (!v[i].ill) chk($sformatf("v%0d_led", i), 64'(led), 64'(4'bzz0z));
`endif
            tick();
            chk($sformatf("v%0d_pulse_off", i), 64'(done_pulse), 64'(0));
            chk($sformatf("v%0d_sticky", i), 64'(status[3:0]), 64'({1'b0, v[i].ill, 2'b10}));
        end
        opcode = OP_MUL; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        opcode = OP_AND; operand_a = '0; operand_b = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovr_set", 64'(status[3:0]), 64'(4'b1001));
        lat = 11;
        while (!done_pulse && lat < 100) begin
            tick();
            lat++;
        end
        exp_cnt++;
        chk("ovr_lat", 64'(lat), 64'(33));
        chk("ovr_result", {result_hi, result_lo}, 64'd15);
        chk("ovr_status", 64'(status), 64'(es(exp_cnt, 1'b0, 1'b1, 1'b0, 1'b1)));
        tick();
        issue(OP_ADD, 32'd1, 32'd1, lat);
        chk("ovr_clear", 64'(status), 64'(es(exp_cnt, 1'b0, 1'b0, 1'b0, 1'b1)));
        chk("add_lo", 64'(result_lo), 64'(2));
        opcode = OP_XOR; operand_a = 32'hFFFF; operand_b = 32'h1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_ign", 64'(status), 64'(es(exp_cnt, 1'b0, 1'b1, 1'b0, 1'b1)));
        tick(); tick();
        chk("done_start_nopulse", 64'(done_pulse), 64'(0));
        chk("done_start_lo", 64'(result_lo), 64'(2));
        opcode = OP_MUL; operand_a = 32'd7; operand_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        chk("mrst_res", {result_hi, result_lo}, 64'd0);
        chk("mrst_status", 64'(status), 64'(0));
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_pulse) pulses++;
            tick();
        end
        chk("mrst_no_pulse", 64'(pulses), 64'(0));
        for (int i = 0; i < 5; i++) begin
            issue(OP_ADD, 32'(i), 32'd1, lat);
            chk($sformatf("wrap%0d_cnt", i), 64'(status[31:16]), 64'(exp_cnt));
            chk($sformatf("wrap%0d_cnt2", i), 64'(status2[31:16]), 64'(exp_cnt % 4));
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
